// File: rtl/alu_byte_sequencer_pkg.sv
// Shared op codes, flag bit positions, FSM encodings and the latched-op record
// for the byte-serial ALU sequencer.
package alu_byte_sequencer_pkg;

  localparam logic [2:0] ALU_OP_ADD = 3'd0;
  localparam logic [2:0] ALU_OP_ADC = 3'd1;
  localparam logic [2:0] ALU_OP_SUB = 3'd2;
  localparam logic [2:0] ALU_OP_SBC = 3'd3;
  localparam logic [2:0] ALU_OP_AND = 3'd4;
  localparam logic [2:0] ALU_OP_OR  = 3'd5;
  localparam logic [2:0] ALU_OP_XOR = 3'd6;
  localparam logic [2:0] ALU_OP_MOV = 3'd7;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_Z = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;

  typedef struct packed {
    logic [2:0]  code;
    logic        wide;
    logic [2:0]  dst;
    logic [2:0]  src;
    logic        use_imm;
    logic [15:0] imm;
    logic        set_flags;
  } op_t;

  function automatic logic op_is_sub(input logic [2:0] op);
    return (op == ALU_OP_SUB) || (op == ALU_OP_SBC);
  endfunction

endpackage

// File: rtl/alu_byte_sequencer_alu8_slice.sv
// Combinational 8-bit ALU slice; carry_out is reported in flag sense
// (borrow for SUB/SBC), while cin is the raw adder carry-in.
module alu8_slice
  import alu_byte_sequencer_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] result,
  output logic       carry_out,
  output logic       overflow,
  output logic       zero
);

  logic [7:0] b_eff;
  logic [8:0] sum;

  // Adder with operand inversion for subtraction, plus logic/move results
  always_comb begin
    b_eff     = op_is_sub(op) ? ~b : b;
    sum       = {1'b0, a} + {1'b0, b_eff} + {8'd0, cin};
    result    = 8'h00;
    carry_out = 1'b0;
    overflow  = 1'b0;
    case (op)
      ALU_OP_ADD, ALU_OP_ADC, ALU_OP_SUB, ALU_OP_SBC: begin
        result    = sum[7:0];
        carry_out = op_is_sub(op) ? ~sum[8] : sum[8];
        overflow  = (a[7] == b_eff[7]) && (sum[7] != a[7]);
      end
      ALU_OP_AND: result = a & b;
      ALU_OP_OR:  result = a | b;
      ALU_OP_XOR: result = a ^ b;
      ALU_OP_MOV: result = b;
      default:    result = 8'h00;
    endcase
    zero = (result == 8'h00);
  end

endmodule

// File: rtl/alu_byte_sequencer.sv
// Sequences 8/16-bit register ops onto one 8-bit ALU slice, keeps the V/C/S/Z
// flags and shares the register-file write port with the load-data path.
module alu_byte_sequencer
  import alu_byte_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_code,
  input  logic        op_wide,
  input  logic [2:0]  op_dst,
  input  logic [2:0]  op_src,
  input  logic        op_use_imm,
  input  logic [15:0] op_imm,
  input  logic        op_set_flags,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [2:0]  ld_addr,
  input  logic [7:0]  ld_data,
  output logic [2:0]  rf_raddr_a,
  output logic [2:0]  rf_raddr_b,
  input  logic [7:0]  rf_rdata_a,
  input  logic [7:0]  rf_rdata_b,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [7:0]  rf_wdata,
  output logic [3:0]  flags,
  output logic        busy
);

  logic [1:0] state_q, state_d;
  op_t        op_q, op_d;
  logic [3:0] flags_q, flags_d;
  logic       c_lo_q, c_lo_d;
  logic       z_lo_q, z_lo_d;

  logic       in_lo, in_hi, exec, last_exec, accept, ld_grant;
  logic [7:0] alu_b, alu_res;
  logic       alu_cin, alu_c, alu_v, alu_z;

  // Handshakes: loads only in IDLE, and a pending load blocks new ops so the
  // exec stream drains to IDLE where the load is served.
  always_comb begin
    in_lo     = (state_q == ST_LO);
    in_hi     = (state_q == ST_HI);
    exec      = in_lo | in_hi;
    last_exec = (in_lo & ~op_q.wide) | in_hi;
    op_ready  = ~reset & ~ld_valid & ((state_q == ST_IDLE) | last_exec);
    ld_ready  = ~reset & (state_q == ST_IDLE);
    accept    = op_valid & op_ready;
    ld_grant  = ld_valid & ld_ready;
    busy      = ~reset & exec;
    flags     = flags_q;
  end

  // Byte addressing and operand/carry-in selection for the current half
  always_comb begin
    if (in_hi) begin
      rf_raddr_a = {op_q.dst[2:1], 1'b1};
      rf_raddr_b = {op_q.src[2:1], 1'b1};
    end else if (op_q.wide) begin
      rf_raddr_a = {op_q.dst[2:1], 1'b0};
      rf_raddr_b = {op_q.src[2:1], 1'b0};
    end else begin
      rf_raddr_a = op_q.dst;
      rf_raddr_b = op_q.src;
    end

    if (op_q.use_imm) begin
      alu_b = in_hi ? op_q.imm[15:8] : op_q.imm[7:0];
    end else begin
      alu_b = rf_rdata_b;
    end

    // High byte chains the low-byte carry/borrow, never the flag register
    if (in_hi) begin
      alu_cin = op_is_sub(op_q.code) ? ~c_lo_q : c_lo_q;
    end else begin
      case (op_q.code)
        ALU_OP_ADC: alu_cin = flags_q[FLAG_C];
        ALU_OP_SUB: alu_cin = 1'b1;
        ALU_OP_SBC: alu_cin = ~flags_q[FLAG_C];
        default:    alu_cin = 1'b0;
      endcase
    end
  end

  alu8_slice u_slice (
    .op        (op_q.code),
    .a         (rf_rdata_a),
    .b         (alu_b),
    .cin       (alu_cin),
    .result    (alu_res),
    .carry_out (alu_c),
    .overflow  (alu_v),
    .zero      (alu_z)
  );

  // Write port: exec cycles own it; a granted load uses it only in IDLE
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rf_raddr_a;
    rf_wdata = alu_res;
    if (reset) begin
      rf_we = 1'b0;
    end else if (exec) begin
      rf_we = 1'b1;
    end else if (ld_grant) begin
      rf_we    = 1'b1;
      rf_waddr = ld_addr;
      rf_wdata = ld_data;
    end else begin
      rf_we = 1'b0;
    end
  end

  // Next-state, op latch and flag update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    flags_d = flags_q;
    c_lo_d  = c_lo_q;
    z_lo_d  = z_lo_q;

    if (in_lo) begin
      c_lo_d = alu_c;
      z_lo_d = alu_z;
    end else begin
      c_lo_d = c_lo_q;
    end

    if (last_exec && op_q.set_flags && (op_q.code != ALU_OP_MOV)) begin
      flags_d[FLAG_V] = alu_v;
      flags_d[FLAG_C] = alu_c;
      flags_d[FLAG_S] = alu_res[7];
      flags_d[FLAG_Z] = in_hi ? (z_lo_q & alu_z) : alu_z;
    end else begin
      flags_d = flags_q;
    end

    case (state_q)
      ST_IDLE: state_d = accept ? ST_LO : ST_IDLE;
      ST_LO:   state_d = op_q.wide ? ST_HI : (accept ? ST_LO : ST_IDLE);
      ST_HI:   state_d = accept ? ST_LO : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      op_d.code      = op_code;
      op_d.wide      = op_wide;
      op_d.dst       = op_dst;
      op_d.src       = op_src;
      op_d.use_imm   = op_use_imm;
      op_d.imm       = op_imm;
      op_d.set_flags = op_set_flags;
    end else begin
      op_d = op_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      flags_q <= 4'h0;
      c_lo_q  <= 1'b0;
      z_lo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      flags_q <= flags_d;
      c_lo_q  <= c_lo_d;
      z_lo_q  <= z_lo_d;
    end
  end

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Directed bench for alu_byte_sequencer with a behavioural 8x8 register file
// and a log of every register-file write.
module tb_alu_byte_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_ready;
  logic [2:0]  op_code, op_dst, op_src;
  logic        op_wide, op_use_imm, op_set_flags;
  logic [15:0] op_imm;
  logic        ld_valid, ld_ready;
  logic [2:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [2:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [7:0]  rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we, busy;
  logic [3:0]  flags;

  logic [7:0] rf [0:7];
  logic [2:0] wl_addr [0:63];
  logic [7:0] wl_data [0:63];
  int         wl_n = 0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  always @(posedge clk) begin
    if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
      if (wl_n < 64) begin
        wl_addr[wl_n] <= rf_waddr;
        wl_data[wl_n] <= rf_wdata;
      end
      wl_n <= wl_n + 1;
    end
  end

  alu_byte_sequencer dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_wide(op_wide),
    .op_dst(op_dst), .op_src(op_src), .op_use_imm(op_use_imm), .op_imm(op_imm),
    .op_set_flags(op_set_flags),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flags(flags), .busy(busy)
  );

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_op(input logic [2:0] code, input logic wide, input logic [2:0] dst,
                         input logic [2:0] src, input logic use_imm, input logic [15:0] imm,
                         input logic setf);
    int cnt;
    op_code = code; op_wide = wide; op_dst = dst; op_src = src;
    op_use_imm = use_imm; op_imm = imm; op_set_flags = setf; op_valid = 1'b1;
    cnt = 0;
    #1;
    while (!op_ready && cnt < 10) begin
      @(negedge clk); #1; cnt++;
    end
    tests_run++;
    if (op_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL op_accept: op_ready=%b required 1", op_ready);
    end
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] addr, input logic [7:0] data);
    int cnt;
    ld_addr = addr; ld_data = data; ld_valid = 1'b1;
    cnt = 0;
    #1;
    while (!ld_ready && cnt < 10) begin
      @(negedge clk); #1; cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    ld_valid = 1'b0;
    tests_run++;
    if (rf[addr] !== data) begin
      tests_failed++;
      $display("FAIL load r%0d: got %h required %h", addr, rf[addr], data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({rf_we, op_ready, ld_ready, busy, flags} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_outputs: we/ordy/lrdy/busy/flags=%b required 00000000",
               {rf_we, op_ready, ld_ready, busy, flags});
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if ({op_ready, ld_ready, busy, flags} !== 7'b1100000) begin
      tests_failed++;
      $display("FAIL post_reset_idle: ordy/lrdy/busy/flags=%b required 1100000",
               {op_ready, ld_ready, busy, flags});
    end
    @(negedge clk);
  endtask

  task automatic test_narrow_add();
    do_load(3'd2, 8'h7F);
    do_load(3'd3, 8'h01);
    send_op(3'd0, 1'b0, 3'd2, 3'd3, 1'b0, 16'h0000, 1'b1);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL add_busy: busy=%b required 1", busy);
    end
    @(negedge clk);
    tests_run++;
    if (rf[2] !== 8'h80 || flags !== 4'b1010) begin
      tests_failed++;
      $display("FAIL narrow_add: r2=%h flags=%b required r2=80 flags=1010", rf[2], flags);
    end
  endtask

  task automatic test_wide_sub();
    do_load(3'd2, 8'h00);
    do_load(3'd3, 8'h01);
    send_op(3'd2, 1'b1, 3'd2, 3'd0, 1'b1, 16'h0001, 1'b1);
    @(negedge clk);
    tests_run++;
    if (rf[2] !== 8'hFF || rf[3] !== 8'h01) begin
      tests_failed++;
      $display("FAIL wide_sub_lo: r2=%h r3=%h required FF 01", rf[2], rf[3]);
    end
    @(negedge clk);
    tests_run++;
    if (rf[3] !== 8'h00 || flags !== 4'b0000) begin
      tests_failed++;
      $display("FAIL wide_sub_hi: r3=%h flags=%b required 00 0000", rf[3], flags);
    end
    send_op(3'd2, 1'b1, 3'd2, 3'd0, 1'b1, 16'h00FF, 1'b1);
    repeat (2) @(negedge clk);
    tests_run++;
    if ({rf[3], rf[2]} !== 16'h0000 || flags !== 4'b0001) begin
      tests_failed++;
      $display("FAIL wide_sub_zero: pair=%h flags=%b required 0000 0001", {rf[3], rf[2]}, flags);
    end
  endtask

  task automatic test_wide_adc();
    do_load(3'd0, 8'hFF);
    do_load(3'd1, 8'h01);
    send_op(3'd0, 1'b0, 3'd0, 3'd1, 1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    tests_run++;
    if (rf[0] !== 8'h00 || flags !== 4'b0101) begin
      tests_failed++;
      $display("FAIL set_carry: r0=%h flags=%b required 00 0101", rf[0], flags);
    end
    do_load(3'd4, 8'hFF);
    do_load(3'd5, 8'h00);
    send_op(3'd1, 1'b1, 3'd4, 3'd0, 1'b1, 16'h0000, 1'b1);
    repeat (2) @(negedge clk);
    tests_run++;
    if ({rf[5], rf[4]} !== 16'h0100 || flags !== 4'b0000) begin
      tests_failed++;
      $display("FAIL wide_adc_c1: pair=%h flags=%b required 0100 0000", {rf[5], rf[4]}, flags);
    end
    // Flag C is now 0, so only the chained low-byte carry can reach the high byte
    do_load(3'd4, 8'hFF);
    do_load(3'd5, 8'h00);
    send_op(3'd1, 1'b1, 3'd4, 3'd0, 1'b1, 16'h0001, 1'b1);
    repeat (2) @(negedge clk);
    tests_run++;
    if ({rf[5], rf[4]} !== 16'h0100 || flags !== 4'b0000) begin
      tests_failed++;
      $display("FAIL wide_adc_chain: pair=%h flags=%b required 0100 0000", {rf[5], rf[4]}, flags);
    end
  endtask

  task automatic test_logic_mov();
    do_load(3'd1, 8'h5A);
    send_op(3'd6, 1'b0, 3'd1, 3'd1, 1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    tests_run++;
    if (rf[1] !== 8'h00 || flags !== 4'b0001) begin
      tests_failed++;
      $display("FAIL xor_self: r1=%h flags=%b required 00 0001", rf[1], flags);
    end
    send_op(3'd7, 1'b0, 3'd0, 3'd0, 1'b1, 16'h0080, 1'b1);
    @(negedge clk);
    tests_run++;
    if (rf[0] !== 8'h80 || flags !== 4'b0001) begin
      tests_failed++;
      $display("FAIL mov_flags: r0=%h flags=%b required 80 0001", rf[0], flags);
    end
  endtask

  task automatic test_reset_in_hi();
    do_load(3'd4, 8'h10);
    do_load(3'd5, 8'h20);
    send_op(3'd0, 1'b1, 3'd4, 3'd0, 1'b1, 16'h0101, 1'b1);
    @(negedge clk);
    tests_run++;
    if (rf[4] !== 8'h11 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL hi_setup: r4=%h busy=%b required 11 1", rf[4], busy);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({rf_we, op_ready, ld_ready, busy} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_gating: we/ordy/lrdy/busy=%b required 0000",
               {rf_we, op_ready, ld_ready, busy});
    end
    @(negedge clk);
    tests_run++;
    if (rf[5] !== 8'h20 || flags !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_abort: r5=%h flags=%b required 20 0000", rf[5], flags);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (op_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: op_ready=%b busy=%b required 1 0", op_ready, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [2:0] dsts [0:3];
    logic [7:0] vals [0:3];
    logic [2:0] exp_a [0:4];
    logic [7:0] exp_d [0:4];
    int k, cyc, start, ready_low;
    logic fire_op, fire_ld, ld_raised;
    dsts[0] = 3'd0; dsts[1] = 3'd1; dsts[2] = 3'd2; dsts[3] = 3'd3;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    exp_a[0] = 3'd0; exp_a[1] = 3'd7; exp_a[2] = 3'd1; exp_a[3] = 3'd2; exp_a[4] = 3'd3;
    exp_d[0] = 8'h11; exp_d[1] = 8'hA5; exp_d[2] = 8'h22; exp_d[3] = 8'h33; exp_d[4] = 8'h44;
    start = wl_n; k = 0; cyc = 0; ready_low = 0; ld_raised = 1'b0;
    op_code = 3'd7; op_wide = 1'b0; op_use_imm = 1'b1; op_set_flags = 1'b0; op_src = 3'd0;
    op_dst = dsts[0]; op_imm = {8'h00, vals[0]}; op_valid = 1'b1;
    while (k < 4 && cyc < 40) begin
      if (k == 1 && !ld_raised) begin
        ld_valid = 1'b1; ld_addr = 3'd7; ld_data = 8'hA5; ld_raised = 1'b1;
      end
      #1;
      fire_op = op_valid & op_ready;
      fire_ld = ld_valid & ld_ready;
      if (op_valid && !op_ready) ready_low++;
      @(negedge clk);
      cyc++;
      if (fire_ld) ld_valid = 1'b0;
      if (fire_op) begin
        k++;
        if (k < 4) begin
          op_dst = dsts[k]; op_imm = {8'h00, vals[k]};
        end else begin
          op_valid = 1'b0;
        end
      end
    end
    op_valid = 1'b0;
    ld_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (cyc !== 6 || ready_low !== 2) begin
      tests_failed++;
      $display("FAIL b2b_timing: cycles=%0d stalls=%0d required 6 2", cyc, ready_low);
    end
    tests_run++;
    if (wl_n - start !== 5) begin
      tests_failed++;
      $display("FAIL b2b_write_count: got %0d required 5", wl_n - start);
    end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (wl_addr[start + i] !== exp_a[i] || wl_data[start + i] !== exp_d[i]) begin
        tests_failed++;
        $display("FAIL b2b_write%0d: r%0d=%h required r%0d=%h", i,
                 wl_addr[start + i], wl_data[start + i], exp_a[i], exp_d[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_code = 3'd0; op_wide = 1'b0; op_dst = 3'd0;
    op_src = 3'd0; op_use_imm = 1'b0; op_imm = 16'h0000; op_set_flags = 1'b0;
    ld_valid = 1'b0; ld_addr = 3'd0; ld_data = 8'h00;
    test_reset();
    test_narrow_add();
    test_wide_sub();
    test_wide_adc();
    test_logic_mov();
    test_reset_in_hi();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
